dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single DataMem port between two requesters: the pipeline memory-access stage (CPU port) and a debug/loader port (DBG port).
- Arbitration is CPU-priority with a starvation guard for DBG, plus a DBG lock mode for multi-beat program loading.
- Sits between the memory-access stage and DataMem; drives the pipeline stall when the CPU loses arbitration.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive cycles DBG may wait before it is forced a grant (1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request (load or store)
- cpu_wen  in  1  CPU store
- cpu_size  in  2  CPU access size (MemSize encoding)
- cpu_sign  in  1  CPU load sign-extend
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  CPU load data, combinational from mem_rdata
- cpu_stall  out  1  CPU request not served this cycle
- dbg_req  in  1  DBG access request
- dbg_lock  in  1  hold DBG ownership while asserted
- dbg_wen  in  1  DBG store
- dbg_size  in  2  DBG size
- dbg_sign  in  1  DBG sign-extend
- dbg_addr  in  ADDR_W  DBG address
- dbg_wdata  in  DATA_W  DBG store data
- dbg_gnt  out  1  DBG request served this cycle
- dbg_rvalid  out  1  registered DBG read data valid
- dbg_rdata  out  DATA_W  registered DBG read data
- mem_addr  out  ADDR_W  to DataMem Addr
- mem_size  out  2  to DataMem Size
- mem_sign  out  1  to DataMem load_extend_sign
- mem_wen  out  1  to DataMem WEN
- mem_wdata  out  DATA_W  to DataMem DataIn
- mem_rdata  in  DATA_W  from DataMem DataOut

Behaviour:
- Clock/reset: one clock, clk; reset rst_n asynchronous, active-low. On reset: state=IDLE, starve_cnt=0, dbg_rvalid=0, dbg_rdata=0.
- Ownership per cycle is decided combinationally from the current state and requests, at one access per cycle. DataMem writes take effect at the clk edge. Reads are combinational.
- FSM states: IDLE, CPU_OWN, DBG_OWN, DBG_LOCKED. The state records the last owner and the lock.
- Grant rule, evaluated when not in DBG_LOCKED:
  - DBG wins if dbg_req && (!cpu_req || starve_cnt==STARVE_LIMIT).
  - Otherwise CPU wins if cpu_req.
  - Otherwise there is no owner.
- DBG_LOCKED:
  - Entered when DBG wins with dbg_lock=1.
  - DBG always owns. cpu_stall=cpu_req.
  - Exits to IDLE on the edge where dbg_lock=0 is sampled.
  - dbg_req=0 inside the lock generates no access, but the lock is held.
- Next state: DBG_OWN or CPU_OWN after a grant to that requester; IDLE when neither requests.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, each cycle dbg_req=1 and DBG is not granted.
  - Clears when DBG is granted or dbg_req=0.
- Mux: mem_* fields come from the owner. When there is no owner, mem_wen=0 and the other mem_* fields are 0.
- mem_wen = owner_wen only. A non-owner can never write.
- cpu_stall = cpu_req && owner!=CPU (combinational, same cycle).
- cpu_rdata = mem_rdata whenever the CPU owns; otherwise 0.
- dbg_gnt = owner==DBG && dbg_req.
- DBG read response:
  - On a granted DBG read (dbg_wen=0), dbg_rdata<=mem_rdata and dbg_rvalid<=1 at the next edge, so latency is 1 cycle.
  - dbg_rvalid is a 1-cycle pulse; dbg_rdata holds its value until the next DBG read.
- Simultaneous requests with starve_cnt<STARVE_LIMIT: the CPU wins. The starvation guarantee is that DBG is served within STARVE_LIMIT+1 cycles of a continuous request.
- Reset during DBG_LOCKED: the block returns to IDLE immediately and the CPU is unstalled.
- Requesters must hold request fields stable while stalled or not granted.

Decomposition:
- Shared package (mem_pkg):
  - MemSize encodings (byte/half/word)
  - FSM state enum
  - ADDR_W/DATA_W defaults
- One sub-module is natural: arb_starve_counter (saturating counter with clear, inc, and at_limit flag).
- Muxing, the FSM and the response register stay in dmem_arbiter.

Test Plan:
- CPU only: store word 0xDEADBEEF to 0x40, then load 0x40 → mem_wen=1 for 1 cycle, cpu_rdata=0xDEADBEEF, cpu_stall=0 and dbg_gnt=0 throughout.
- DBG only: write 0x12345678 to 0x80, then read 0x80 → dbg_gnt=1 each cycle; dbg_rvalid pulses 1 cycle after the read grant with dbg_rdata=0x12345678.
- Contention with STARVE_LIMIT=4: cpu_req and dbg_req held high → CPU granted cycles 0-3, DBG granted cycle 4 with cpu_stall=1 in that cycle only, then CPU again and starve_cnt=0.
- Lock: dbg_lock=1 plus 3 DBG writes while cpu_req=1 → cpu_stall=1 throughout; the CPU resumes the cycle after dbg_lock falls; memory holds all 3 words.
- Reset mid-lock: assert rst_n=0 asynchronously during DBG_LOCKED → outputs drop immediately to reset values (mem_wen=0, dbg_rvalid=0, cpu_stall=0, and the 0 no-owner values on the other mem_* fields whether or not cpu_req=1). After release, cpu_req is served the first cycle.
- Idle: no requests → mem_wen=0, all mem_* fields=0, and DataMem contents unchanged over 10 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared DataMem encodings and arbiter types
package mem_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CPU_OWN    = 2'd1,
        DBG_OWN    = 2'd2,
        DBG_LOCKED = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;
endpackage

// File: rtl/arb_starve_counter.sv
// rtl/arb_starve_counter.sv - saturating DBG wait counter with clear
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);
    logic [3:0] count;

    assign at_limit = (count == 4'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + 4'd1;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority DataMem arbiter with DBG starvation guard and lock
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_sign,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_lock,
    input  logic              dbg_wen,
    input  logic [1:0]        dbg_size,
    input  logic              dbg_sign,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    arb_state_e state;
    owner_e     owner;
    logic       at_limit;
    logic       dbg_access;
    logic       cpu_access;

    // Owner is forced to none while reset is held so the port goes quiet at once.
    always_comb begin
        owner = OWN_NONE;
        if (!rst_n) begin
            owner = OWN_NONE;
        end else if (state == DBG_LOCKED) begin
            owner = OWN_DBG;
        end else if (dbg_req && (!cpu_req || at_limit)) begin
            owner = OWN_DBG;
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end
    end

    assign dbg_access = (owner == OWN_DBG) && dbg_req;
    assign cpu_access = (owner == OWN_CPU);
    assign dbg_gnt    = dbg_access;
    assign cpu_stall  = rst_n && cpu_req && !cpu_access;
    assign cpu_rdata  = cpu_access ? mem_rdata : '0;

    always_comb begin
        mem_addr  = '0;
        mem_size  = '0;
        mem_sign  = 1'b0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        if (dbg_access) begin
            mem_addr  = dbg_addr;
            mem_size  = dbg_size;
            mem_sign  = dbg_sign;
            mem_wen   = dbg_wen;
            mem_wdata = dbg_wdata;
        end else if (cpu_access) begin
            mem_addr  = cpu_addr;
            mem_size  = cpu_size;
            mem_sign  = cpu_sign;
            mem_wen   = cpu_wen;
            mem_wdata = cpu_wdata;
        end
    end

    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (dbg_access || !dbg_req),
        .inc      (dbg_req && !dbg_access),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            dbg_rvalid <= dbg_access && !dbg_wen;
            if (dbg_access && !dbg_wen) begin
                dbg_rdata <= mem_rdata;
            end
            if (state == DBG_LOCKED) begin
                if (!dbg_lock) begin
                    state <= IDLE;
                end
            end else begin
                case (owner)
                    OWN_DBG: state <= dbg_lock ? DBG_LOCKED : DBG_OWN;
                    OWN_CPU: state <= CPU_OWN;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_wen, cpu_sign, dbg_req, dbg_lock, dbg_wen, dbg_sign;
    logic [1:0]  cpu_size, dbg_size, mem_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_addr, dbg_wdata, dbg_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, dbg_gnt, dbg_rvalid, mem_sign, mem_wen;

    logic [31:0] mem  [0:63];
    logic [31:0] gold [0:63];
    logic [31:0] snap [0:63];
    logic        mem_ready = 1'b0;
    logic        gold_ready = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_size(cpu_size), .cpu_sign(cpu_sign),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_wen(dbg_wen), .dbg_size(dbg_size),
        .dbg_sign(dbg_sign), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_size(mem_size), .mem_sign(mem_sign), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h01010101) ^ 32'hA5000000;
    endfunction

    // DataMem stand-in: combinational read, write at the edge.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (mem_wen) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who is served, what memory holds, what DBG reads back.
    logic        m_locked = 1'b0;
    int          m_wait = 0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        cw, dw, e_wen, e_sign, e_stall;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata, e_crd;

    always @(negedge clk) begin
        if (!gold_ready) begin
            for (int i = 0; i < 64; i++) gold[i] = init_word(i);
            gold_ready = 1'b1;
        end
        cw = 0; dw = 0; e_wen = 0; e_sign = 0; e_size = 0;
        e_addr = 0; e_wdata = 0; e_crd = 0; e_stall = 0;
        if (rst_n) begin
            if (m_locked) dw = dbg_req;
            else if (dbg_req && (!cpu_req || m_wait == LIMIT)) dw = 1;
            else cw = cpu_req;
            if (dw) begin
                e_wen = dbg_wen; e_addr = dbg_addr; e_wdata = dbg_wdata;
                e_size = dbg_size; e_sign = dbg_sign;
            end else if (cw) begin
                e_wen = cpu_wen; e_addr = cpu_addr; e_wdata = cpu_wdata;
                e_size = cpu_size; e_sign = cpu_sign; e_crd = gold[cpu_addr[7:2]];
            end
            e_stall = cpu_req && !cw && !(m_locked == 0 && 0);
            e_stall = cpu_req && !cw;
        end else begin
            m_locked = 0; m_wait = 0; m_rvalid = 0; m_rdata = 0;
        end
        chk("m_cpu_stall", cpu_stall, e_stall);
        chk("m_dbg_gnt", dbg_gnt, dw);
        chk("m_mem_wen", mem_wen, e_wen);
        chk("m_mem_addr", mem_addr, e_addr);
        chk("m_mem_wdata", mem_wdata, e_wdata);
        chk("m_mem_size", mem_size, e_size);
        chk("m_mem_sign", mem_sign, e_sign);
        chk("m_cpu_rdata", cpu_rdata, e_crd);
        chk("m_dbg_rvalid", dbg_rvalid, m_rvalid);
        chk("m_dbg_rdata", dbg_rdata, m_rdata);
        if (rst_n) begin
            if (dw && !dbg_wen) begin
                m_rvalid = 1; m_rdata = gold[dbg_addr[7:2]];
            end else begin
                m_rvalid = 0;
            end
            if (dw && dbg_wen) gold[dbg_addr[7:2]] = dbg_wdata;
            if (cw && cpu_wen) gold[cpu_addr[7:2]] = cpu_wdata;
            m_wait = (dbg_req && !dw) ? ((m_wait == LIMIT) ? LIMIT : m_wait + 1) : 0;
            m_locked = m_locked ? dbg_lock : (dw && dbg_lock);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        cpu_req = r; cpu_wen = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic dbg(input logic r, input logic l, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        dbg_req = r; dbg_lock = l; dbg_wen = w; dbg_addr = a; dbg_wdata = d;
    endtask

    logic [6:0] stall_bits, gnt_bits;
    int         diffs;

    initial begin
        rst_n = 1'b0;
        cpu(0, 0, 0, 0); dbg(0, 0, 0, 0, 0);
        cpu_size = 2'd2; cpu_sign = 1'b0; dbg_size = 2'd2; dbg_sign = 1'b1;
        #2;
        chk("rst_dbg_rvalid", dbg_rvalid, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // CPU only: store then load
        cpu(1, 1, 32'h40, 32'hDEADBEEF);
        sample(); chk("t1_st_wen", mem_wen, 1); chk("t1_st_stall", cpu_stall, 0);
        step();
        cpu(1, 0, 32'h40, 0);
        sample(); chk("t1_ld_rdata", cpu_rdata, 32'hDEADBEEF); chk("t1_ld_wen", mem_wen, 0);
        chk("t1_ld_gnt", dbg_gnt, 0);
        step();
        cpu(0, 0, 0, 0);
        step();

        // DBG only: write then read, 1-cycle response
        dbg(1, 0, 1, 32'h80, 32'h12345678);
        sample(); chk("t2_wr_gnt", dbg_gnt, 1);
        step();
        dbg(1, 0, 0, 32'h80, 0);
        sample(); chk("t2_rd_gnt", dbg_gnt, 1); chk("t2_rd_rvalid_early", dbg_rvalid, 0);
        step();
        dbg(0, 0, 0, 0, 0);
        sample(); chk("t2_rvalid", dbg_rvalid, 1); chk("t2_rdata", dbg_rdata, 32'h12345678);
        step();
        sample(); chk("t2_rvalid_pulse", dbg_rvalid, 0); chk("t2_rdata_hold", dbg_rdata, 32'h12345678);
        step();

        // Contention: DBG forced in on the fifth cycle
        cpu(1, 0, 32'h40, 0); dbg(1, 0, 0, 32'h44, 0);
        stall_bits = '0; gnt_bits = '0;
        for (int c = 0; c < 7; c++) begin
            sample(); stall_bits[c] = cpu_stall; gnt_bits[c] = dbg_gnt;
            step();
        end
        chk("t3_stall_pattern", 32'(stall_bits), 32'h10);
        chk("t3_gnt_pattern", 32'(gnt_bits), 32'h10);
        cpu(0, 0, 0, 0); dbg(0, 0, 0, 0, 0);
        step();

        // Lock: three DBG writes with the CPU held off
        dbg(1, 1, 1, 32'h10, 32'h11111111);
        sample(); chk("t4_gnt0", dbg_gnt, 1);
        step();
        cpu(1, 1, 32'h30, 32'hC0FFEE00); dbg(1, 1, 1, 32'h14, 32'h22222222);
        sample(); chk("t4_stall1", cpu_stall, 1);
        step();
        dbg(1, 1, 1, 32'h18, 32'h33333333);
        sample(); chk("t4_stall2", cpu_stall, 1);
        step();
        dbg(0, 1, 0, 0, 0);
        sample(); chk("t4_stall_hold", cpu_stall, 1); chk("t4_noacc_wen", mem_wen, 0);
        step();
        dbg(0, 0, 0, 0, 0);
        sample(); chk("t4_stall_exit", cpu_stall, 1);
        step();
        sample(); chk("t4_cpu_resume", cpu_stall, 0); chk("t4_cpu_wen", mem_wen, 1);
        step();
        cpu(0, 0, 0, 0);
        step();
        chk("t4_mem0", mem[4], 32'h11111111);
        chk("t4_mem1", mem[5], 32'h22222222);
        chk("t4_mem2", mem[6], 32'h33333333);
        chk("t4_cpu_mem", mem[12], 32'hC0FFEE00);

        // Reset while locked
        dbg(1, 1, 0, 32'h80, 0);
        sample(); chk("t5_gnt", dbg_gnt, 1);
        step();
        cpu(1, 1, 32'h34, 32'h55AA55AA); dbg(0, 1, 0, 0, 0);
        #2;
        chk("t5_pre_rvalid", dbg_rvalid, 1);
        chk("t5_pre_stall", cpu_stall, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rvalid", dbg_rvalid, 0);
        chk("t5_wen", mem_wen, 0);
        chk("t5_stall", cpu_stall, 0);
        chk("t5_addr", mem_addr, 0);
        chk("t5_wdata", mem_wdata, 0);
        chk("t5_rdata", dbg_rdata, 0);
        dbg(0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        sample(); chk("t5_cpu_first", cpu_stall, 0); chk("t5_cpu_wen", mem_wen, 1);
        chk("t5_cpu_addr", mem_addr, 32'h34);
        step();
        cpu(0, 0, 0, 0);
        step();

        // Idle: nothing touches memory
        for (int i = 0; i < 64; i++) snap[i] = mem[i];
        for (int c = 0; c < 10; c++) begin
            sample(); chk("t6_idle_wen", mem_wen, 0); chk("t6_idle_addr", mem_addr, 0);
            step();
        end
        diffs = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== snap[i]) diffs++;
        chk("t6_mem_unchanged", diffs, 0);
        chk("t6_mem_t5", mem[13], 32'h55AA55AA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
